// File: rtl/mcdf_sched_pkg.sv
// mcdf_sched_pkg: shared types, length codes and decode helper for the MCDF WRR scheduler
package mcdf_sched_pkg;
  typedef enum logic {IDLE, XFER} state_t;
  localparam int DEF_NUM_CH = 3;
  localparam logic [2:0] LEN_4W = 3'd0;
  localparam logic [2:0] LEN_8W = 3'd1;
  localparam logic [2:0] LEN_16W = 3'd2;
  localparam logic [2:0] LEN_32W = 3'd3;
  function automatic logic [5:0] pkglen_words(input logic [2:0] code);
    return code > LEN_32W ? 6'd32 : 6'd4 << code[1:0];
  endfunction
endpackage

// File: rtl/mcdf_rr_pick.sv
// mcdf_rr_pick: combinational rotating-priority finder, first set bit of elig at or after ptr
module mcdf_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] elig,
  input  logic [1:0]   ptr,
  output logic         found,
  output logic [1:0]   idx
);
  // walk from farthest to nearest so the nearest eligible channel wins
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx = 2'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/mcdf_wrr_sched.sv
// mcdf_wrr_sched: weighted round-robin packet scheduler for the formatter; MCDF_SCHED_STAT_EN adds grant counters
module mcdf_wrr_sched
  import mcdf_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DW = 32,
  parameter int WW = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic [NUM_CH*WW-1:0] weight_i,
  input  logic [NUM_CH*3-1:0]  pkglen_i,
  input  logic [NUM_CH-1:0]    req_i,
  input  logic [NUM_CH-1:0]    val_i,
  input  logic [NUM_CH*DW-1:0] data_i,
  output logic [NUM_CH-1:0]    ack_o,
  input  logic                 f2s_id_req_i,
  input  logic                 f2s_ack_i,
  output logic                 s2f_val_o,
  output logic [1:0]           s2f_id_o,
  output logic [DW-1:0]        s2f_data_o,
  output logic [2:0]           s2f_pkglen_sel_o
`ifdef MCDF_SCHED_STAT_EN
  ,
  output logic [NUM_CH*16-1:0] grant_cnt_o
`endif
);
  state_t state, state_nx;
  logic [WW-1:0] credit [NUM_CH];
  logic [WW-1:0] reload [NUM_CH];
  logic [NUM_CH-1:0] has_credit;
  logic [1:0] ptr, idx_c, idx_r, win, nxt_ch;
  logic [5:0] beat_cnt, len;
  logic [2:0] win_code;
  logic found_c, found_r, start, beat, last;
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_cr
    assign has_credit[i] = |credit[i];
    assign reload[i] = weight_i[i*WW +: WW] == '0 ? WW'(1) : weight_i[i*WW +: WW];
  end
  mcdf_rr_pick #(.N(NUM_CH)) u_pick_c (.elig(req_i & has_credit), .ptr(ptr), .found(found_c), .idx(idx_c));
  mcdf_rr_pick #(.N(NUM_CH)) u_pick_r (.elig(req_i), .ptr(ptr), .found(found_r), .idx(idx_r));
  assign win = found_c ? idx_c : idx_r;
  assign win_code = pkglen_i[int'(win)*3 +: 3];
  assign start = (state == IDLE) & en_i & f2s_id_req_i & found_r;
  assign beat = (state == XFER) & val_i[s2f_id_o] & f2s_ack_i;
  assign last = beat & (beat_cnt == len - 6'd1);
  assign nxt_ch = s2f_id_o == 2'(NUM_CH - 1) ? 2'd0 : s2f_id_o + 2'd1;
  assign s2f_val_o = (state == XFER) & val_i[s2f_id_o];
  assign s2f_data_o = state == XFER ? data_i[int'(s2f_id_o)*DW +: DW] : '0;
  assign ack_o = beat ? NUM_CH'(1) << s2f_id_o : '0;
  // next state: a grant opens a packet, its final beat closes it
  always_comb begin
    state_nx = start ? XFER : last ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else state <= state_nx;
  end
  // grant capture, beat counting and credit/pointer bookkeeping
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr <= '0;
      beat_cnt <= '0;
      len <= '0;
      s2f_id_o <= '0;
      s2f_pkglen_sel_o <= '0;
      for (int k = 0; k < NUM_CH; k++) credit[k] <= '0;
    end else begin
      if (start) begin
        s2f_id_o <= win;
        s2f_pkglen_sel_o <= win_code;
        len <= pkglen_words(win_code);
        beat_cnt <= '0;
        if (!found_c) for (int k = 0; k < NUM_CH; k++) credit[k] <= reload[k];
      end
      if (beat) beat_cnt <= beat_cnt + 6'd1;
      if (last) begin
        if (credit[s2f_id_o] != '0) credit[s2f_id_o] <= credit[s2f_id_o] - WW'(1);
        ptr <= credit[s2f_id_o] > WW'(1) ? s2f_id_o : nxt_ch;
      end
    end
  end
`ifdef MCDF_SCHED_STAT_EN
  logic [15:0] gcnt [NUM_CH];
  // per-channel grant counters that hold at full scale
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) for (int k = 0; k < NUM_CH; k++) gcnt[k] <= '0;
    else if (start && gcnt[win] != 16'hFFFF) gcnt[win] <= gcnt[win] + 16'd1;
  end
  for (i = 0; i < NUM_CH; i++) begin : g_stat
    assign grant_cnt_o[i*16 +: 16] = gcnt[i];
  end
`endif
endmodule

// File: tb/tb_mcdf_wrr_sched.sv
// tb_mcdf_wrr_sched: scoreboard bench for the weighted round-robin scheduler
module tb_mcdf_wrr_sched;
  localparam int NCH = 3;
  localparam int DW = 32;
  localparam int WW = 3;
  logic clk_i = 1'b0, rstn_i = 1'b1, en_i = 1'b1, f2s_id_req_i = 1'b0, f2s_ack_i = 1'b1;
  logic [NCH*WW-1:0] weight_i = '0;
  logic [NCH*3-1:0] pkglen_i = '0;
  logic [NCH-1:0] req_i = '0, val_i = '0, ack_o, ea;
  logic [NCH*DW-1:0] data_i;
  logic s2f_val_o;
  logic [1:0] s2f_id_o;
  logic [DW-1:0] s2f_data_o;
  logic [2:0] s2f_pkglen_sel_o;
`ifdef MCDF_SCHED_STAT_EN
  logic [NCH*16-1:0] grant_cnt_o;
`endif
  typedef struct {int id; int len; logic [2:0] code;} exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int tests = 0, fails = 0, pkts_done = 0, beats = 0;
  bit active = 0, chk_idle = 0;

  mcdf_wrr_sched #(.NUM_CH(NCH), .DW(DW), .WW(WW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .weight_i(weight_i), .pkglen_i(pkglen_i),
    .req_i(req_i), .val_i(val_i), .data_i(data_i), .ack_o(ack_o), .f2s_id_req_i(f2s_id_req_i),
    .f2s_ack_i(f2s_ack_i), .s2f_val_o(s2f_val_o), .s2f_id_o(s2f_id_o), .s2f_data_o(s2f_data_o),
    .s2f_pkglen_sel_o(s2f_pkglen_sel_o)
`ifdef MCDF_SCHED_STAT_EN
    , .grant_cnt_o(grant_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] ch_data(input int c);
    return 32'hA500_0000 + DW'(c) * 32'h0001_0101;
  endfunction

  function automatic int words(input logic [2:0] c);
    return c > 3'd3 ? 32 : 4 << c;
  endfunction

  // scoreboard: pop the expected grant on the first valid word, check every cycle of the packet
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      active = 0;
      chk_idle = 0;
      beats = 0;
      exp_q.delete();
    end else begin
      if (chk_idle) begin
        chk_idle = 0;
        tests++;
        if (s2f_val_o !== 1'b0) begin
          fails++;
          $display("FAIL pkt_end_idle: s2f_val_o=%0b exp 0", s2f_val_o);
        end
      end else if (!active && s2f_val_o) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_grant: id=%0d with no grant expected", s2f_id_o);
        end else begin
          cur = exp_q.pop_front();
          active = 1;
          beats = 0;
          if (s2f_id_o !== 2'(cur.id) || s2f_pkglen_sel_o !== cur.code) begin
            fails++;
            $display("FAIL grant: id=%0d code=%0d exp id=%0d code=%0d", s2f_id_o, s2f_pkglen_sel_o, cur.id, cur.code);
          end
        end
      end
      if (active) begin
        ea = (val_i[cur.id] && f2s_ack_i) ? NCH'(1) << cur.id : '0;
        tests++;
        if (ack_o !== ea || (s2f_val_o && s2f_data_o !== ch_data(cur.id))) begin
          fails++;
          $display("FAIL beat: ack=%b data=%h exp ack=%b data=%h", ack_o, s2f_data_o, ea, ch_data(cur.id));
        end
        if (s2f_val_o && f2s_ack_i) begin
          beats++;
          if (beats == cur.len) begin
            active = 0;
            pkts_done++;
            chk_idle = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rstn_i = 1'b0;
    f2s_id_req_i = 1'b0;
    en_i = 1'b1;
    f2s_ack_i = 1'b1;
    val_i = '1;
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic send_pkt(input int id, input logic [2:0] code);
    int d;
    int n;
    exp_q.push_back('{id: id, len: words(code), code: code});
    d = pkts_done;
    f2s_id_req_i = 1'b1;
    tick();
    f2s_id_req_i = 1'b0;
    n = 0;
    while (pkts_done == d && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (pkts_done == d) begin
      fails++;
      $display("FAIL pkt_timeout: ch %0d packet done=%0d exp %0d", id, pkts_done, d + 1);
    end
  endtask

  task automatic test_reset();
    req_i = '1;
    val_i = '1;
    f2s_ack_i = 1'b1;
    f2s_id_req_i = 1'b1;
    #2 rstn_i = 1'b0;
    #1;
    tests += 5;
    if (s2f_id_o !== 2'd0) begin fails++; $display("FAIL reset_id: %0d exp 0", s2f_id_o); end
    if (s2f_pkglen_sel_o !== 3'd0) begin fails++; $display("FAIL reset_len: %0d exp 0", s2f_pkglen_sel_o); end
    if (ack_o !== '0) begin fails++; $display("FAIL reset_ack: %b exp 0", ack_o); end
    if (s2f_val_o !== 1'b0) begin fails++; $display("FAIL reset_val: %b exp 0", s2f_val_o); end
    if (s2f_data_o !== '0) begin fails++; $display("FAIL reset_data: %h exp 0", s2f_data_o); end
    f2s_id_req_i = 1'b0;
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int ord[5] = '{0, 1, 2, 0, 1};
    int prev;
    int d;
    int n;
    reset_dut();
    weight_i = {3'd1, 3'd1, 3'd1};
    pkglen_i = '0;
    req_i = '1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{id: ord[i], len: 4, code: 3'd0});
      d = pkts_done;
      f2s_id_req_i = 1'b1;
      @(negedge clk_i);
      tests++;
      if (s2f_id_o !== 2'(prev)) begin fails++; $display("FAIL basic_id_early: %0d exp %0d", s2f_id_o, prev); end
      tick();
      f2s_id_req_i = 1'b0;
      tests++;
      if (s2f_id_o !== 2'(ord[i])) begin fails++; $display("FAIL basic_id: %0d exp %0d", s2f_id_o, ord[i]); end
      n = 0;
      while (pkts_done == d && n < 50) begin
        tick();
        n++;
      end
      tests++;
      if (pkts_done == d) begin fails++; $display("FAIL basic_timeout: pkt %0d not finished", i); end
      prev = ord[i];
    end
  endtask

  task automatic test_weights();
    int ord[8] = '{0, 0, 1, 2, 0, 0, 1, 2};
    reset_dut();
    weight_i = {3'd1, 3'd1, 3'd2};
    pkglen_i = '0;
    req_i = '1;
    for (int i = 0; i < 8; i++) send_pkt(ord[i], 3'd0);
  endtask

  task automatic test_bubbles();
    int d;
    int acked;
    reset_dut();
    weight_i = {3'd1, 3'd1, 3'd1};
    pkglen_i = {3'd0, 3'd3, 3'd0};
    req_i = 3'b010;
    val_i = '0;
    exp_q.push_back('{id: 1, len: 32, code: 3'd3});
    d = pkts_done;
    acked = 0;
    f2s_id_req_i = 1'b1;
    tick();
    f2s_id_req_i = 1'b0;
    for (int n = 0; n < 200 && pkts_done == d; n++) begin
      val_i[1] = n[0];
      f2s_ack_i = (n % 3) != 2;
      @(negedge clk_i);
      tests++;
      if (ack_o[1] !== (val_i[1] & f2s_ack_i)) begin
        fails++;
        $display("FAIL bubble_ack: ack=%b val=%b f2s_ack=%b", ack_o[1], val_i[1], f2s_ack_i);
      end
      if (ack_o[1]) acked++;
      tick();
    end
    tests++;
    if (acked !== 32) begin fails++; $display("FAIL bubble_beats: %0d exp 32", acked); end
    val_i = '1;
    f2s_ack_i = 1'b1;
    @(negedge clk_i);
    tests++;
    if (s2f_val_o !== 1'b0 || ack_o !== '0) begin
      fails++;
      $display("FAIL bubble_idle: val=%b ack=%b exp 0 0", s2f_val_o, ack_o);
    end
    tick();
  endtask

  task automatic test_weight0();
    reset_dut();
    weight_i = '0;
    pkglen_i = '0;
    req_i = 3'b100;
    for (int i = 0; i < 3; i++) send_pkt(2, 3'd0);
  endtask

  task automatic test_en_drop();
    int d;
    int n;
    reset_dut();
    weight_i = {3'd1, 3'd1, 3'd1};
    pkglen_i = {3'd1, 3'd1, 3'd1};
    req_i = '1;
    exp_q.push_back('{id: 0, len: 8, code: 3'd1});
    d = pkts_done;
    f2s_id_req_i = 1'b1;
    tick();
    f2s_id_req_i = 1'b0;
    n = 0;
    while (beats < 5 && n < 50) begin
      tick();
      n++;
    end
    en_i = 1'b0;
    pkglen_i = '0;
    weight_i = {3'd4, 3'd4, 3'd4};
    n = 0;
    while (pkts_done == d && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (pkts_done == d) begin fails++; $display("FAIL en_drop_finish: packet not completed"); end
    f2s_id_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      tests++;
      if (s2f_val_o !== 1'b0 || s2f_id_o !== 2'd0) begin
        fails++;
        $display("FAIL en_drop_idle: val=%b id=%0d exp 0 0", s2f_val_o, s2f_id_o);
      end
      tick();
    end
    f2s_id_req_i = 1'b0;
    en_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    reset_dut();
    weight_i = {3'd1, 3'd1, 3'd1};
    pkglen_i = '0;
    req_i = '1;
    send_pkt(0, 3'd0);
    exp_q.push_back('{id: 1, len: 4, code: 3'd0});
    f2s_id_req_i = 1'b1;
    tick();
    f2s_id_req_i = 1'b0;
    n = 0;
    while (beats < 3 && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (beats < 3) begin fails++; $display("FAIL rst_mid_start: beats=%0d exp 3", beats); end
    rstn_i = 1'b0;
    #1;
    tests++;
    if (s2f_val_o !== 1'b0 || ack_o !== '0 || s2f_id_o !== 2'd0 || s2f_data_o !== '0 || s2f_pkglen_sel_o !== 3'd0) begin
      fails++;
      $display("FAIL rst_mid_outputs: val=%b ack=%b id=%0d data=%h len=%0d exp all 0",
               s2f_val_o, ack_o, s2f_id_o, s2f_data_o, s2f_pkglen_sel_o);
    end
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
    send_pkt(0, 3'd0);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) data_i[c*DW +: DW] = ch_data(c);
    test_reset();
    test_basic();
    test_weights();
    test_bubbles();
    test_weight0();
    test_en_drop();
    test_reset_mid();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mcdf_wrr_sched.md
Name: mcdf_wrr_sched

Overview:
- Weighted round-robin packet scheduler for the MCDF formatter path.
- Shares one formatter between NUM_CH slave channels and grants one channel per formatter id request.
- Holds the grant for exactly one packet of the channel's programmed length.
- Per-channel weights from registers set how many consecutive packets a channel may send before the grant rotates.

Parameters:
- NUM_CH, 3, number of slave channels (2..4)
- DW, 32, data width
- WW, 3, weight field width per channel

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- en_i  in  1  scheduler enable (register bit)
- weight_i  in  NUM_CH*WW  per-channel weight; 0 is treated as 1
- pkglen_i  in  NUM_CH*3  per-channel packet length code
- req_i  in  NUM_CH  channel has a packet pending
- val_i  in  NUM_CH  channel data word valid
- data_i  in  NUM_CH*DW  channel data words, channel k at [k*DW +: DW]
- ack_o  out  NUM_CH  word accepted, to channel
- f2s_id_req_i  in  1  formatter ready for the next packet
- f2s_ack_i  in  1  formatter accepts the current word
- s2f_val_o  out  1  word valid to formatter
- s2f_id_o  out  2  granted channel id
- s2f_data_o  out  DW  granted channel data
- s2f_pkglen_sel_o  out  3  granted channel length code

Behaviour:
- Clock and reset: single clock clk_i; asynchronous active-low reset rstn_i.
- Reset values: state IDLE; credits all 0; ptr 0; beat_cnt 0; s2f_id_o 0; s2f_pkglen_sel_o 0; ack_o 0; s2f_val_o 0; s2f_data_o 0.
- Length decode: code 0/1/2/3 = 4/8/16/32 words; codes 4..7 = 32 words.
- FSM, IDLE:
  - Advance when en_i=1, f2s_id_req_i=1 and |req_i.
  - Arbitrate in that cycle.
  - Register winner g into s2f_id_o and its code into s2f_pkglen_sel_o.
  - Latch packet length; clear beat_cnt; go XFER next cycle (latency 1).
  - Otherwise stay IDLE with s2f_id_o unchanged.
- Arbitration:
  - Rotating search from ptr for the first channel with req_i=1 and credit>0.
  - If no requester has credit, reload every credit from max(weight,1) and search again in the same cycle.
- FSM, XFER (datapath combinational):
  - s2f_val_o = val_i[g].
  - s2f_data_o = data_i[g].
  - ack_o[g] = f2s_ack_i & val_i[g]; other ack_o bits 0.
- Beat counting:
  - A beat is val_i[g] & f2s_ack_i; increments beat_cnt.
  - On the beat where beat_cnt == len-1: decrement credit[g] and go IDLE.
  - Then ptr = g if the remaining credit > 0, else ptr = (g+1) mod NUM_CH.
- Boundary conditions:
  - val_i low mid-packet inserts bubbles; the grant is held.
  - req_i[g] dropping mid-packet does not end the packet.
  - en_i deasserted in XFER: current packet completes, no new grant is issued.
  - weight_i or pkglen_i changes mid-packet do not affect the current packet; new weights apply at the next reload.
  - f2s_id_req_i is ignored in XFER.
  - Reset mid-packet aborts immediately to reset values.
- Credit width is WW bits; it never underflows.

Optional Feature:
- Macro: MCDF_SCHED_STAT_EN.
- With macro: adds output grant_cnt_o (NUM_CH*16).
  - One 16-bit counter per channel, incremented on each grant.
  - Saturates at 0xFFFF; cleared by reset.
- Without macro: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package mcdf_sched_pkg: state enum {IDLE, XFER}, pkglen decode function (code to word count), length-code constants, default NUM_CH.
- Sub-module mcdf_rr_pick: combinational rotating-priority finder.
  - Inputs: eligible mask, ptr. Outputs: found, index.
  - Instantiated twice: credited search and post-reload search.

Test Plan:
- Weights all 1, pkglen all 0, all req_i=1, val and ack held 1, five id requests:
  - Grants are 0,1,2,0,1.
  - Each packet is 4 beats.
  - s2f_id_o updates one cycle after the id request.
- Weights 2/1/1, all requesting, eight packets: grant order 0,0,1,2,0,0,1,2.
- Ch1 pkglen=3, val_i[1] toggling every other cycle:
  - Exactly 32 acked beats; ack_o[1] only when val and ack are both high.
  - Returns to IDLE after beat 32.
- Only ch2 requesting, weight 0: repeated grants to ch2, with credit reload each packet.
- en_i cleared during beat 5 of an 8-word packet:
  - Packet finishes.
  - A following f2s_id_req_i yields no grant and state stays IDLE.
- rstn_i asserted at beat 3:
  - All outputs return to 0 immediately.
  - After release, first grant goes to the lowest-index requester.
